pac_man_mover: RTL and testbench

- Downstream stage of pac_man_behavior. Consumes each requested `next_block` and checks it against the maze/pellet map RAM.
- Commits legal moves to the authoritative `curr_block`, which is fed back to pac_man_behavior.
- Eats pellets, keeps score, runs the power-pellet timer and flags level clear.
- Rate-limits movement so Pac-Man advances at most one block per MOVE_PERIOD cycles.

---
 rtl/pac_man_mover.sv | 145 ++++++++++++++
 tb/tb_pac_man_mover.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pac_man_mover.sv
// pac_man_mover: takes each requested block from pac_man_behavior, looks it up
// in the maze/pellet map RAM, and commits legal moves to curr_block. It also
// eats pellets, keeps the score, runs the power-pellet timer, flags level
// clear, and limits movement to one block per MOVE_PERIOD cycles.
module pac_man_mover #(
  parameter int COLS         = 32,
  parameter int ROWS         = 24,
  parameter int START_BLOCK  = 495,
  parameter int PELLET_COUNT = 240,
  parameter int MOVE_PERIOD  = 4,
  parameter int POWER_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       req_valid,
  input  logic [9:0] next_block,
  output logic       ack,
  output logic       move_ok,
  output logic [9:0] curr_block,
  output logic [9:0] map_addr,
  input  logic [1:0] map_rdata,
  output logic       map_we,
  output logic [1:0] map_wdata,
  output logic [15:0] score,
  output logic [9:0] pellets_left,
  output logic       power_active,
  output logic       level_clear
);

  localparam logic [10:0] BLOCKS = 11'(COLS * ROWS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    READ,
    CHECK,
    ACK
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [9:0]  req_blk;
  logic        committed;
  logic [15:0] step_cnt;
  logic [15:0] power_cnt;
  logic        accept;
  logic        commit;
  logic        eat;
  logic        in_range;
  logic [16:0] score_sum;

  assign in_range     = ({1'b0, next_block} < BLOCKS);
  assign power_active = (power_cnt != 16'd0);
  assign score_sum    = {1'b0, score} + (map_rdata[0] ? 17'd50 : 17'd10);

  // State register; reset parks the mover in IDLE until the next start.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus the per-cycle strobes (ack, RAM port, commit/eat).
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    eat        = 1'b0;
    ack        = 1'b0;
    move_ok    = 1'b0;
    map_we     = 1'b0;
    map_addr   = 10'd0;
    map_wdata  = 2'b00;
    case (state)
      IDLE: state_next = IDLE;
      WAIT_REQ: begin
        if (req_valid && (step_cnt == 16'd0) && !level_clear) begin
          accept = 1'b1;
          if (in_range && (next_block != curr_block)) state_next = READ;
          else                                        state_next = ACK;
        end
      end
      READ: begin
        map_addr   = req_blk;
        state_next = CHECK;
      end
      CHECK: begin
        map_addr   = req_blk;
        commit     = (map_rdata != 2'b01);
        eat        = map_rdata[1];
        map_we     = map_rdata[1];
        state_next = ACK;
      end
      ACK: begin
        ack        = 1'b1;
        move_ok    = committed;
        state_next = WAIT_REQ;
      end
      default: state_next = IDLE;
    endcase
    if (start) state_next = WAIT_REQ;
    if (reset || start) begin
      accept   = 1'b0;
      commit   = 1'b0;
      eat      = 1'b0;
      ack      = 1'b0;
      move_ok  = 1'b0;
      map_we   = 1'b0;
      map_addr = 10'd0;
    end
  end

  // Game state: position, score, pellets, rate limiter and power timer.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      curr_block   <= 10'(START_BLOCK);
      score        <= 16'd0;
      pellets_left <= 10'(PELLET_COUNT);
      level_clear  <= 1'b0;
      step_cnt     <= 16'd0;
      power_cnt    <= 16'd0;
      committed    <= 1'b0;
      req_blk      <= 10'd0;
    end else begin
      if (step_cnt != 16'd0)  step_cnt  <= step_cnt - 16'd1;
      if (power_cnt != 16'd0) power_cnt <= power_cnt - 16'd1;
      if (accept) begin
        req_blk   <= next_block;
        committed <= 1'b0;
      end
      if (commit) begin
        curr_block <= req_blk;
        committed  <= 1'b1;
        step_cnt   <= 16'(MOVE_PERIOD - 1);
      end
      if (eat) begin
        score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (pellets_left != 10'd0) pellets_left <= pellets_left - 10'd1;
        if (pellets_left == 10'd1) level_clear <= 1'b1;
        if (map_rdata == 2'b11) power_cnt <= 16'(POWER_CYCLES);
      end
    end
  end

endmodule

// File: tb/tb_pac_man_mover.sv
// Testbench for pac_man_mover: a map RAM model, a reference model that
// predicts each ack (timing, move_ok, position, score, pellets) into a
// scoreboard queue, and per-cycle checks of the power timer.
module tb_pac_man_mover;
  localparam int COLS         = 32;
  localparam int ROWS         = 24;
  localparam int START_BLOCK  = 495;
  localparam int PELLET_COUNT = 240;
  localparam int MOVE_PERIOD  = 4;
  localparam int POWER_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        req_valid;
  logic [9:0]  next_block;
  logic        ack;
  logic        move_ok;
  logic [9:0]  curr_block;
  logic [9:0]  map_addr;
  logic [1:0]  map_rdata;
  logic        map_we;
  logic [1:0]  map_wdata;
  logic [15:0] score;
  logic [9:0]  pellets_left;
  logic        power_active;
  logic        level_clear;

  pac_man_mover #(
    .COLS(COLS), .ROWS(ROWS), .START_BLOCK(START_BLOCK),
    .PELLET_COUNT(PELLET_COUNT), .MOVE_PERIOD(MOVE_PERIOD),
    .POWER_CYCLES(POWER_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .req_valid(req_valid),
    .next_block(next_block), .ack(ack), .move_ok(move_ok),
    .curr_block(curr_block), .map_addr(map_addr), .map_rdata(map_rdata),
    .map_we(map_we), .map_wdata(map_wdata), .score(score),
    .pellets_left(pellets_left), .power_active(power_active),
    .level_clear(level_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Initial maze contents: pellets on 0..299, specific test blocks elsewhere.
  function automatic logic [1:0] initMap(input int i);
    if (i < 300)   return 2'b10;
    if (i == 497)  return 2'b10;
    if (i == 528)  return 2'b01;
    if (i == 600 || i == 601) return 2'b11;
    return 2'b00;
  endfunction

  // Map RAM: loaded on the first edge, then 1-cycle read latency with write.
  logic [1:0] ram [1024];
  logic       ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= initMap(i);
      ram_loaded <= 1'b1;
    end else begin
      if (map_we) ram[map_addr] <= map_wdata;
      map_rdata <= ram[map_addr];
    end
  end

  typedef struct {
    int          ack_cyc;
    logic        ok;
    logic [9:0]  curr;
    logic [15:0] score;
    logic [9:0]  pellets;
    logic        clear;
    int          we_cnt;
    int          power_end;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] mdl_map [1024];
  int         m_curr, m_score, m_pellets, m_last_commit, m_power_end;
  logic       m_clear;
  int         tests_run = 0;
  int         tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic powerCheck();
    checkOutput("power_active", {31'd0, power_active}, {31'd0, (cyc < m_power_end)});
  endtask

  task automatic modelStart();
    m_curr        = START_BLOCK;
    m_score       = 0;
    m_pellets     = PELLET_COUNT;
    m_clear       = 1'b0;
    m_last_commit = -100;
    m_power_end   = 0;
  endtask

  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    modelStart();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput("idle_ack", {31'd0, ack}, 0);
      powerCheck();
    end
  endtask

  task automatic applyIgnored(input int blk, input int n);
    int acks = 0;
    req_valid  = 1'b1;
    next_block = 10'(blk);
    repeat (n) begin
      @(negedge clk);
      if (ack) acks++;
    end
    req_valid = 1'b0;
    checkOutput("ignored_ack", acks, 0);
  endtask

  // Drive one request, predict its outcome, and hold req_valid until ack.
  task automatic applyStimulus(input int blk);
    exp_t       e;
    exp_t       p;
    int         r, a, lat;
    int         we_seen = 0;
    logic       got_ack = 1'b0;
    logic [1:0] t;
    r          = cyc;
    req_valid  = 1'b1;
    next_block = 10'(blk);
    a = r;
    if (m_last_commit + MOVE_PERIOD - 1 > a) a = m_last_commit + MOVE_PERIOD - 1;
    e.ok        = 1'b0;
    e.we_cnt    = 0;
    e.power_end = m_power_end;
    if (blk < COLS * ROWS && blk != m_curr) begin
      lat = 3;
      t   = mdl_map[blk];
      if (t != 2'b01) begin
        e.ok   = 1'b1;
        m_curr = blk;
      end
      if (t[1]) begin
        m_score = m_score + ((t == 2'b11) ? 50 : 10);
        if (m_score > 65535) m_score = 65535;
        if (m_pellets > 0) m_pellets--;
        if (m_pellets == 0) m_clear = 1'b1;
        mdl_map[blk] = 2'b00;
        e.we_cnt = 1;
        if (t == 2'b11) e.power_end = a + lat + POWER_CYCLES;
      end
    end else begin
      lat = 1;
    end
    e.ack_cyc = a + lat;
    if (e.ok) m_last_commit = e.ack_cyc;
    e.curr    = 10'(m_curr);
    e.score   = 16'(m_score);
    e.pellets = 10'(m_pellets);
    e.clear   = m_clear;
    sb.push_back(e);

    for (int i = 0; i < 60 && !got_ack; i++) begin
      @(negedge clk);
      if (map_we) we_seen++;
      if (ack) begin
        got_ack     = 1'b1;
        req_valid   = 1'b0;
        p           = sb.pop_front();
        m_power_end = p.power_end;
        checkOutput("ack_latency", cyc - r, p.ack_cyc - r);
        checkOutput("move_ok", {31'd0, move_ok}, {31'd0, p.ok});
        checkOutput("curr_block", {22'd0, curr_block}, {22'd0, p.curr});
        checkOutput("score", {16'd0, score}, {16'd0, p.score});
        checkOutput("pellets_left", {22'd0, pellets_left}, {22'd0, p.pellets});
        checkOutput("level_clear", {31'd0, level_clear}, {31'd0, p.clear});
        checkOutput("map_we_count", we_seen, p.we_cnt);
        if (p.we_cnt != 0) checkOutput("ram_cleared", {30'd0, ram[blk]}, 0);
      end
      powerCheck();
    end
    if (!got_ack) begin
      checkOutput("ack_timeout", {31'd0, got_ack}, 1);
      req_valid   = 1'b0;
      p           = sb.pop_front();
      m_power_end = p.power_end;
    end
    @(negedge clk);
    checkOutput("ack_pulse", {31'd0, ack}, 0);
    powerCheck();
  endtask

  initial begin
    int acks;
    reset      = 1'b1;
    start      = 1'b0;
    req_valid  = 1'b0;
    next_block = 10'd0;
    for (int i = 0; i < 1024; i++) mdl_map[i] = initMap(i);
    modelStart();
    repeat (3) @(negedge clk);

    checkOutput("rst_curr_block", {22'd0, curr_block}, START_BLOCK);
    checkOutput("rst_score", {16'd0, score}, 0);
    checkOutput("rst_pellets", {22'd0, pellets_left}, PELLET_COUNT);
    checkOutput("rst_power", {31'd0, power_active}, 0);
    checkOutput("rst_clear", {31'd0, level_clear}, 0);
    checkOutput("rst_ack", {31'd0, ack}, 0);
    checkOutput("rst_move_ok", {31'd0, move_ok}, 0);
    checkOutput("rst_map_we", {31'd0, map_we}, 0);
    checkOutput("rst_map_addr", {22'd0, map_addr}, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] requests in IDLE are ignored");
    applyIgnored(496, 10);

    $display("[TB] start and basic moves");
    doStart();
    applyStimulus(496);
    applyStimulus(497);
    applyStimulus(497);
    applyStimulus(528);
    applyStimulus(800);

    $display("[TB] power pellets");
    applyStimulus(600);
    applyStimulus(601);
    idleCycles(20);

    $display("[TB] clearing the level");
    for (int i = 0; i < 300 && m_pellets > 0; i++) applyStimulus(i);
    checkOutput("level_clear_final", {31'd0, level_clear}, 1);
    applyIgnored(300, 20);

    $display("[TB] restart");
    doStart();
    @(negedge clk);
    checkOutput("start_curr_block", {22'd0, curr_block}, START_BLOCK);
    checkOutput("start_score", {16'd0, score}, 0);
    checkOutput("start_pellets", {22'd0, pellets_left}, PELLET_COUNT);
    checkOutput("start_clear", {31'd0, level_clear}, 0);
    idleCycles(4);

    $display("[TB] reset during READ");
    req_valid  = 1'b1;
    next_block = 10'd299;
    @(negedge clk);
    acks  = ack ? 1 : 0;
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    modelStart();
    repeat (8) begin
      @(negedge clk);
      if (ack) acks++;
    end
    checkOutput("reset_read_ack", acks, 0);
    checkOutput("reset_read_curr", {22'd0, curr_block}, START_BLOCK);
    checkOutput("reset_read_ram", {30'd0, ram[299]}, 2);
    applyIgnored(299, 8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
